// File: rtl/accel_cmd_dispatch.sv
// Command front-end for the systolic accelerator: buffers host commands, issues them one at a time, returns readback rows.
// Optional watchdog on the done wait is compiled in with `define CMD_TIMEOUT_EN.
module accel_cmd_dispatch #(
    parameter int         WIDTH_HEIGHT   = 8,
    parameter int         DATA_WIDTH     = 8,
    parameter int         MAX_MAT_WH     = 128,
    parameter int         CMD_DEPTH      = 4,
    parameter logic [2:0] RD_OPCODE      = 3'b101,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             cmd_valid,
    output logic                                             cmd_ready,
    input  logic [2:0]                                       cmd_opcode,
    input  logic [$clog2(WIDTH_HEIGHT)-1:0]                  cmd_dim_1,
    input  logic [$clog2(WIDTH_HEIGHT)-1:0]                  cmd_dim_2,
    input  logic [$clog2(WIDTH_HEIGHT)-1:0]                  cmd_dim_3,
    input  logic [7:0]                                       cmd_addr,
    input  logic [$clog2(MAX_MAT_WH/WIDTH_HEIGHT)-1:0]       cmd_submat_row,
    input  logic [$clog2(MAX_MAT_WH/WIDTH_HEIGHT)-1:0]       cmd_submat_col,
    input  logic [WIDTH_HEIGHT*DATA_WIDTH-1:0]               cmd_wr_data,
    output logic                                             start,
    output logic [2:0]                                       opcode,
    output logic [$clog2(WIDTH_HEIGHT)-1:0]                  dim_1,
    output logic [$clog2(WIDTH_HEIGHT)-1:0]                  dim_2,
    output logic [$clog2(WIDTH_HEIGHT)-1:0]                  dim_3,
    output logic [7:0]                                       addr_1,
    output logic [$clog2(MAX_MAT_WH/WIDTH_HEIGHT)-1:0]       accum_table_submat_row_in,
    output logic [$clog2(MAX_MAT_WH/WIDTH_HEIGHT)-1:0]       accum_table_submat_col_in,
    output logic [WIDTH_HEIGHT*DATA_WIDTH-1:0]               inputMem_wr_data,
    output logic [WIDTH_HEIGHT*DATA_WIDTH-1:0]               weightMem_wr_data,
    input  logic                                             done,
    input  logic [WIDTH_HEIGHT*DATA_WIDTH*2-1:0]             outputMem_rd_data,
    output logic                                             rsp_valid,
    input  logic                                             rsp_ready,
    output logic [WIDTH_HEIGHT*DATA_WIDTH*2-1:0]             rsp_data,
    output logic                                             busy,
    output logic [$clog2(CMD_DEPTH):0]                       cmd_count,
    output logic                                             err_timeout
);

    localparam int DIM_W = $clog2(WIDTH_HEIGHT);
    localparam int SUB_W = $clog2(MAX_MAT_WH/WIDTH_HEIGHT);
    localparam int ROW_W = WIDTH_HEIGHT*DATA_WIDTH;
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [DIM_W-1:0] dim_1;
        logic [DIM_W-1:0] dim_2;
        logic [DIM_W-1:0] dim_3;
        logic [7:0]       addr;
        logic [SUB_W-1:0] submat_row;
        logic [SUB_W-1:0] submat_col;
        logic [ROW_W-1:0] wr_data;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_n;
    cmd_t             fifo_mem [CMD_DEPTH];
    cmd_t             cmd_in, act;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop, is_rd, wd_expire;

    assign cmd_in    = {cmd_opcode, cmd_dim_1, cmd_dim_2, cmd_dim_3, cmd_addr,
                        cmd_submat_row, cmd_submat_col, cmd_wr_data};
    assign cmd_ready = !reset && (count < CNT_W'(CMD_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign is_rd     = (act.opcode == RD_OPCODE);
    assign cmd_count = count;

    assign opcode                    = act.opcode;
    assign dim_1                     = act.dim_1;
    assign dim_2                     = act.dim_2;
    assign dim_3                     = act.dim_3;
    assign addr_1                    = act.addr;
    assign accum_table_submat_row_in = act.submat_row;
    assign accum_table_submat_col_in = act.submat_col;
    assign inputMem_wr_data          = act.wr_data;
    assign weightMem_wr_data         = act.wr_data;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: if (count != '0) begin
                pop     = 1'b1;
                state_n = ISSUE;
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (done)           state_n = is_rd ? RESP : IDLE;
                else if (wd_expire) state_n = IDLE;
            end
            RESP: if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            act       <= '0;
            start     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state <= state_n;
            if (push) begin
                fifo_mem[wr_ptr] <= cmd_in;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                act    <= fifo_mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            // start is high exactly for the ISSUE cycle
            start <= pop;
            if (state == WAIT && done && is_rd) begin
                rsp_valid <= 1'b1;
                rsp_data  <= outputMem_rd_data;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            busy <= (state != IDLE) || (count != '0);
        end
    end

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt;
    logic            err_q;

    assign wd_expire   = (state == WAIT) && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ISSUE)
                wait_cnt <= '0;
            else if (state == WAIT && !done)
                wait_cnt <= wait_cnt + 1'b1;
            if (wd_expire && !done)
                err_q <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
    // Watchdog compiled out: flag is constant low while still referencing its limit.
    assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_accel_cmd_dispatch.sv
// Scoreboard bench for accel_cmd_dispatch: expected commands queued at push, checked at start; responses checked at handshake.
module tb_accel_cmd_dispatch;
    localparam int         WH    = 8;
    localparam int         DW    = 8;
    localparam int         MW    = 128;
    localparam int         DEPTH = 4;
    localparam logic [2:0] RD    = 3'b101;
    localparam int         TO    = 16;
    localparam int         DIMW  = 3;
    localparam int         SUBW  = 4;
    localparam int         ROWW  = WH*DW;
    localparam int         CW    = 3 + 3*DIMW + 8 + 2*SUBW + ROWW;

    typedef logic [CW-1:0] cmd_v;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_opcode;
    logic [DIMW-1:0] cmd_dim_1, cmd_dim_2, cmd_dim_3;
    logic [7:0]      cmd_addr;
    logic [SUBW-1:0] cmd_submat_row, cmd_submat_col;
    logic [ROWW-1:0] cmd_wr_data;
    logic            start;
    logic [2:0]      opcode;
    logic [DIMW-1:0] dim_1, dim_2, dim_3;
    logic [7:0]      addr_1;
    logic [SUBW-1:0] accum_table_submat_row_in, accum_table_submat_col_in;
    logic [ROWW-1:0] inputMem_wr_data, weightMem_wr_data;
    logic            done;
    logic [2*ROWW-1:0] outputMem_rd_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [2*ROWW-1:0] rsp_data;
    logic            busy;
    logic [2:0]      cmd_count;
    logic            err_timeout;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    cmd_v exp_q[$];
    logic [2*ROWW-1:0] rsp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    accel_cmd_dispatch #(
        .WIDTH_HEIGHT(WH), .DATA_WIDTH(DW), .MAX_MAT_WH(MW), .CMD_DEPTH(DEPTH),
        .RD_OPCODE(RD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_dim_1(cmd_dim_1), .cmd_dim_2(cmd_dim_2), .cmd_dim_3(cmd_dim_3),
        .cmd_addr(cmd_addr), .cmd_submat_row(cmd_submat_row), .cmd_submat_col(cmd_submat_col),
        .cmd_wr_data(cmd_wr_data),
        .start(start), .opcode(opcode), .dim_1(dim_1), .dim_2(dim_2), .dim_3(dim_3),
        .addr_1(addr_1), .accum_table_submat_row_in(accum_table_submat_row_in),
        .accum_table_submat_col_in(accum_table_submat_col_in),
        .inputMem_wr_data(inputMem_wr_data), .weightMem_wr_data(weightMem_wr_data),
        .done(done), .outputMem_rd_data(outputMem_rd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .cmd_count(cmd_count), .err_timeout(err_timeout)
    );

    function automatic cmd_v mk(input logic [2:0] op, input logic [7:0] a);
        return {op, a[2:0], a[5:3], op, a, a[3:0], a[7:4], {8{a ^ 8'h5A}}};
    endfunction

    // Accelerator-side view of the active command; weight data must equal input data.
    function automatic cmd_v act_cmd();
        return {opcode, dim_1, dim_2, dim_3, addr_1, accum_table_submat_row_in,
                accum_table_submat_col_in,
                (weightMem_wr_data === inputMem_wr_data) ? inputMem_wr_data : {ROWW{1'bx}}};
    endfunction

    function automatic cmd_v pop_exp();
        if (exp_q.size() == 0) return {CW{1'bx}};
        return exp_q.pop_front();
    endfunction

    task automatic drive_cmd(input cmd_v c);
        {cmd_opcode, cmd_dim_1, cmd_dim_2, cmd_dim_3, cmd_addr,
         cmd_submat_row, cmd_submat_col, cmd_wr_data} = c;
        cmd_valid = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_cmd(input cmd_v c, output bit ok);
        drive_cmd(c);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) exp_q.push_back(c);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (start) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic pulse_done(input logic [2*ROWW-1:0] d);
        outputMem_rd_data = d;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        outputMem_rd_data = '0;
    endtask

    task automatic test_reset();
        tests++;
        if ({start, rsp_valid, busy, cmd_count, err_timeout} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: start/rsp_valid/busy/count/err=%b want 0", {start, rsp_valid, busy, cmd_count, err_timeout});
        end
        tests++;
        if (act_cmd() !== '0 || rsp_data !== '0) begin
            fails++;
            $display("FAIL reset_fields: fields=%h rsp_data=%h want 0", act_cmd(), rsp_data);
        end
        tests++;
        if (cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: cmd_ready=%b want 0 during reset", cmd_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset: cmd_ready=%b want 1", cmd_ready);
        end
    endtask

    task automatic test_single();
        bit ok, held;
        int pe, se;
        cmd_v e;
        push_cmd(mk(3'b001, 8'h10), ok);
        pe = cyc;
        wait_start(ok);
        se = cyc + 1;
        e = pop_exp();
        tests++;
        if (!ok || act_cmd() !== e) begin
            fails++;
            $display("FAIL single_issue: fields=%h want %h (start seen %0d)", act_cmd(), e, ok);
        end
        tests++;
        if (se !== pe + 2) begin
            fails++;
            $display("FAIL start_latency: start sampled at edge %0d want %0d", se, pe + 2);
        end
        @(negedge clk);
        tests++;
        if (start !== 1'b0) begin
            fails++;
            $display("FAIL start_pulse: start=%b one cycle after issue want 0", start);
        end
        held = 1'b1;
        repeat (4) begin
            if (addr_1 !== 8'h10 || busy !== 1'b1) held = 1'b0;
            @(negedge clk);
        end
        pulse_done('0);
        tests++;
        if (!held || addr_1 !== 8'h10 || busy !== 1'b1) begin
            fails++;
            $display("FAIL addr_hold: addr_1=%h busy=%b held=%0d want 10/1/1", addr_1, busy, held);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || addr_1 !== 8'h10 || err_timeout !== 1'b0) begin
            fails++;
            $display("FAIL busy_drop: busy=%b addr_1=%h err=%b want 0/10/0", busy, addr_1, err_timeout);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int exp_cnt [5] = '{1, 1, 2, 3, 4};
        cmd_v e, c6;
        for (int i = 0; i < 5; i++) begin
            push_cmd(mk(3'b010, 8'h20 + 8'(i)), ok);
            tests++;
            if (!ok || cmd_count !== 3'(exp_cnt[i])) begin
                fails++;
                $display("FAIL b2b_count%0d: count=%0d want %0d", i, cmd_count, exp_cnt[i]);
            end
        end
        e = pop_exp();
        tests++;
        if (act_cmd() !== e || cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_full: fields=%h ready=%b want %h/0", act_cmd(), cmd_ready, e);
        end
        c6 = mk(3'b011, 8'h2F);
        drive_cmd(c6);
        pulse_done('0);
        tests++;
        if (cmd_count !== 3'd4 || cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_held: count=%0d ready=%b want 4/0", cmd_count, cmd_ready);
        end
        @(negedge clk);
        e = pop_exp();
        tests++;
        if (start !== 1'b1 || act_cmd() !== e || cmd_count !== 3'd3) begin
            fails++;
            $display("FAIL b2b_pop: start=%b fields=%h count=%0d want 1/%h/3", start, act_cmd(), cmd_count, e);
        end
        if (cmd_ready) exp_q.push_back(c6);
        @(negedge clk);
        cmd_valid = 1'b0;
        tests++;
        if (cmd_count !== 3'd4) begin
            fails++;
            $display("FAIL b2b_refill: count=%0d want 4", cmd_count);
        end
        repeat (2) @(negedge clk);
        pulse_done('0);
        for (int i = 0; i < 4; i++) begin
            wait_start(ok);
            e = pop_exp();
            tests++;
            if (!ok || act_cmd() !== e) begin
                fails++;
                $display("FAIL b2b_order%0d: fields=%h want %h", i, act_cmd(), e);
            end
            repeat (2) @(negedge clk);
            pulse_done('0);
        end
        @(negedge clk);
        tests++;
        if (cmd_count !== 3'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: count=%0d busy=%b want 0/0", cmd_count, busy);
        end
    endtask

    task automatic test_read();
        bit ok;
        int h, se;
        cmd_v e;
        logic [2*ROWW-1:0] er;
        push_cmd(mk(RD, 8'h33), ok);
        wait_start(ok);
        e = pop_exp();
        tests++;
        if (!ok || act_cmd() !== e) begin
            fails++;
            $display("FAIL rd_issue: fields=%h want %h", act_cmd(), e);
        end
        push_cmd(mk(3'b001, 8'h44), ok);
        rsp_q.push_back(128'hDEAD_BEEF);
        repeat (2) @(negedge clk);
        pulse_done(128'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (rsp_valid !== 1'b1 || rsp_data !== 128'hDEAD_BEEF || start !== 1'b0) begin
                fails++;
                $display("FAIL rsp_hold%0d: valid=%b data=%h start=%b want 1/DEADBEEF/0", i, rsp_valid, rsp_data, start);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        er = (rsp_q.size() != 0) ? rsp_q.pop_front() : {2*ROWW{1'bx}};
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== er) begin
            fails++;
            $display("FAIL rsp_data: valid=%b data=%h want 1/%h", rsp_valid, rsp_data, er);
        end
        @(negedge clk);
        h = cyc;
        rsp_ready = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL rsp_clear: rsp_valid=%b want 0", rsp_valid);
        end
        wait_start(ok);
        se = cyc + 1;
        e = pop_exp();
        tests++;
        if (!ok || act_cmd() !== e || se !== h + 2) begin
            fails++;
            $display("FAIL rd_next: fields=%h start edge %0d want %h at %0d", act_cmd(), se, e, h + 2);
        end
        repeat (2) @(negedge clk);
        pulse_done('0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_done_ignored();
        bit ok, quiet;
        cmd_v e;
        pulse_done('0);
        tests++;
        if (busy !== 1'b0 || start !== 1'b0) begin
            fails++;
            $display("FAIL done_idle: busy=%b start=%b want 0/0", busy, start);
        end
        push_cmd(mk(3'b001, 8'h55), ok);
        wait_start(ok);
        e = pop_exp();
        tests++;
        if (!ok || act_cmd() !== e) begin
            fails++;
            $display("FAIL ign_issue: fields=%h want %h", act_cmd(), e);
        end
        pulse_done('0);
        push_cmd(mk(3'b001, 8'h66), ok);
        quiet = 1'b1;
        repeat (4) begin
            if (start !== 1'b0 || busy !== 1'b1) quiet = 1'b0;
            @(negedge clk);
        end
        tests++;
        if (!quiet || cmd_count !== 3'd1) begin
            fails++;
            $display("FAIL done_issue_ignored: quiet=%0d count=%0d want 1/1", quiet, cmd_count);
        end
        pulse_done('0);
        wait_start(ok);
        e = pop_exp();
        tests++;
        if (!ok || act_cmd() !== e) begin
            fails++;
            $display("FAIL ign_next: fields=%h want %h", act_cmd(), e);
        end
        repeat (2) @(negedge clk);
        pulse_done('0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok, quiet;
        cmd_v e;
        push_cmd(mk(RD, 8'h77), ok);
        wait_start(ok);
        e = pop_exp();
        tests++;
        if (!ok || act_cmd() !== e) begin
            fails++;
            $display("FAIL rst_issue: fields=%h want %h", act_cmd(), e);
        end
        push_cmd(mk(3'b001, 8'h78), ok);
        push_cmd(mk(3'b001, 8'h79), ok);
        tests++;
        if (cmd_count !== 3'd2) begin
            fails++;
            $display("FAIL rst_queued: count=%0d want 2", cmd_count);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (cmd_count !== 3'd0 || start !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_flush: count=%0d start=%b rsp_valid=%b ready=%b busy=%b want 0", cmd_count, start, rsp_valid, cmd_ready, busy);
        end
        reset = 1'b0;
        exp_q.delete();
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (start !== 1'b0 || rsp_valid !== 1'b0 || cmd_count !== 3'd0) quiet = 1'b0;
        end
        tests++;
        if (!quiet) begin
            fails++;
            $display("FAIL rst_quiet: activity after reset (start=%b rsp_valid=%b count=%0d) want none", start, rsp_valid, cmd_count);
        end
    endtask

`ifdef CMD_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int s, seen;
        cmd_v e;
        push_cmd(mk(3'b001, 8'h90), ok);
        wait_start(ok);
        s = cyc;
        e = pop_exp();
        tests++;
        if (!ok || act_cmd() !== e) begin
            fails++;
            $display("FAIL to_issue: fields=%h want %h", act_cmd(), e);
        end
        push_cmd(mk(3'b001, 8'h91), ok);
        seen = -1;
        for (int i = 0; i < 100; i++) begin
            if (err_timeout === 1'b1) begin seen = cyc; break; end
            @(negedge clk);
        end
        tests++;
        if (seen !== s + 17) begin
            fails++;
            $display("FAIL timeout_cycle: err_timeout at cycle %0d want %0d", seen, s + 17);
        end
        wait_start(ok);
        e = pop_exp();
        tests++;
        if (!ok || act_cmd() !== e || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL to_next: fields=%h rsp_valid=%b want %h/0", act_cmd(), rsp_valid, e);
        end
        repeat (2) @(negedge clk);
        pulse_done('0);
        @(negedge clk);
        tests++;
        if (err_timeout !== 1'b1) begin
            fails++;
            $display("FAIL timeout_sticky: err_timeout=%b want 1", err_timeout);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        {cmd_opcode, cmd_dim_1, cmd_dim_2, cmd_dim_3, cmd_addr,
         cmd_submat_row, cmd_submat_col, cmd_wr_data} = '0;
        done = 1'b0;
        outputMem_rd_data = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_read();
        test_done_ignored();
        test_reset_mid();
`ifdef CMD_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
